// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: register-file writeback arbiter with a 2-entry MDU FIFO and an optional pending-write scoreboard.
//   Ports: clk/reset; a_* single-cycle ALU writeback; b_* MDU writeback (valid/ready);
//   iss_* long-latency issue; rs/rt/rd lookup with rd_we and stall; wr_* register-file write port.
//   Macro GPR_WB_ARB_SCOREBOARD_EN enables the pend[] scoreboard; without it stall=0 and iss_ready=1.
module gpr_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_addr,
  output logic          iss_ready,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_we,
  output logic          stall,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state;
  logic [AW-1:0] h_addr, t_addr;
  logic [DW-1:0] h_data, t_data;
  logic a_win, pop, push, b_wr;
  assign b_ready = state != FULL;
  assign a_win = a_valid && a_addr != '0;
  assign pop = !a_win && state != EMPTY;
  assign push = b_valid && b_ready;
  assign b_wr = pop && h_addr != '0;
  always_ff @(posedge clk)
    if (reset) begin
      state <= EMPTY;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= a_win || b_wr;
      if (a_win) begin
        wr_addr <= a_addr;
        wr_data <= a_data;
      end else if (b_wr) begin
        wr_addr <= h_addr;
        wr_data <= h_data;
      end
      if (push && (state == EMPTY || (state == ONE && pop))) begin
        h_addr <= b_addr;
        h_data <= b_data;
      end else if (state == FULL && pop) begin
        h_addr <= t_addr;
        h_data <= t_data;
      end
      if (push && state == ONE && !pop) begin
        t_addr <= b_addr;
        t_data <= b_data;
      end
      state <= (push && !pop) ? (state == EMPTY ? ONE : FULL) :
               (pop && !push) ? (state == FULL ? ONE : EMPTY) : state;
    end
`ifdef GPR_WB_ARB_SCOREBOARD_EN
  logic [2**AW-1:0] pend;
  assign iss_ready = !pend[iss_addr];
  assign stall = pend[rs_addr] | pend[rt_addr] | (rd_we & pend[rd_addr]);
  always_ff @(posedge clk)
    if (reset) pend <= '0;
    else begin
      if (b_wr) pend[h_addr] <= 1'b0;
      if (iss_valid && iss_ready && iss_addr != '0) pend[iss_addr] <= 1'b1;
    end
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_addr, rs_addr, rt_addr, rd_addr, rd_we};
  assign iss_ready = 1'b1;
  assign stall = 1'b0;
`endif
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed self-checking bench for gpr_wb_arbiter.
module tb_gpr_wb_arbiter;
`ifdef GPR_WB_ARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  logic clk = 0, reset = 0;
  logic a_valid = 0, b_valid = 0, iss_valid = 0, rd_we = 0;
  logic [4:0] a_addr = 0, b_addr = 0, iss_addr = 0, rs_addr = 0, rt_addr = 0, rd_addr = 0;
  logic [31:0] a_data = 0, b_data = 0;
  logic b_ready, iss_ready, stall, wr_en;
  logic [4:0] wr_addr;
  logic [31:0] wr_data;
  int checks = 0, failures = 0;
  gpr_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .rd_we(rd_we),
    .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1;
    tick();
    reset = 0;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%0b exp=0", wr_en); end
    checks++; if (wr_addr !== 5'd0) begin failures++; $display("FAIL rst_wr_addr got=%0d exp=0", wr_addr); end
    checks++; if (wr_data !== 32'd0) begin failures++; $display("FAIL rst_wr_data got=%0h exp=0", wr_data); end
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL rst_b_ready got=%0b exp=1", b_ready); end
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL rst_iss_ready got=%0b exp=1", iss_ready); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", stall); end
  endtask
  task automatic test_alu;
    a_valid = 1; a_addr = 3; a_data = 32'h11;
    tick();
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd3, 32'h11}) begin failures++; $display("FAIL alu_write got=%0b/%0d/%0h exp=1/3/11", wr_en, wr_addr, wr_data); end
    a_valid = 0; a_addr = 8; a_data = 32'h22;
    tick();
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b0, 5'd3, 32'h11}) begin failures++; $display("FAIL alu_hold got=%0b/%0d/%0h exp=0/3/11", wr_en, wr_addr, wr_data); end
    a_valid = 1; a_addr = 0; a_data = 32'h55;
    tick();
    a_valid = 0;
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b0, 5'd3, 32'h11}) begin failures++; $display("FAIL alu_r0 got=%0b/%0d/%0h exp=0/3/11", wr_en, wr_addr, wr_data); end
  endtask
  task automatic test_back_to_back;
    a_valid = 1; a_addr = 1; a_data = 32'ha1; b_valid = 1; b_addr = 4; b_data = 32'hb4;
    tick();
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd1, 32'ha1}) begin failures++; $display("FAIL b2b_a1 got=%0b/%0d/%0h exp=1/1/a1", wr_en, wr_addr, wr_data); end
    a_addr = 2; a_data = 32'ha2; b_addr = 5; b_data = 32'hb5;
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_one got=%0b exp=1", b_ready); end
    tick();
    a_addr = 3; a_data = 32'ha3; b_addr = 6; b_data = 32'hb6;
    checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_full got=%0b exp=0", b_ready); end
    tick();
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd3, 32'ha3}) begin failures++; $display("FAIL b2b_a3 got=%0b/%0d/%0h exp=1/3/a3", wr_en, wr_addr, wr_data); end
    a_valid = 0;
    tick();
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd4, 32'hb4}) begin failures++; $display("FAIL b2b_b4 got=%0b/%0d/%0h exp=1/4/b4", wr_en, wr_addr, wr_data); end
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_pop got=%0b exp=1", b_ready); end
    tick();
    b_valid = 0;
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'hb5}) begin failures++; $display("FAIL b2b_b5 got=%0b/%0d/%0h exp=1/5/b5", wr_en, wr_addr, wr_data); end
    tick();
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd6, 32'hb6}) begin failures++; $display("FAIL b2b_b6 got=%0b/%0d/%0h exp=1/6/b6", wr_en, wr_addr, wr_data); end
    tick();
    checks++; if ({wr_en, b_ready} !== 2'b01) begin failures++; $display("FAIL b2b_drain got=%0b/%0b exp=0/1", wr_en, b_ready); end
  endtask
  task automatic test_zero_addr;
    b_valid = 1; b_addr = 7; b_data = 32'h77;
    tick();
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL zero_passthru got=%0b exp=0", wr_en); end
    b_valid = 0; a_valid = 1; a_addr = 0; a_data = 32'hee;
    tick();
    a_valid = 0;
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd7, 32'h77}) begin failures++; $display("FAIL zero_a0_b7 got=%0b/%0d/%0h exp=1/7/77", wr_en, wr_addr, wr_data); end
    b_valid = 1; b_addr = 0; b_data = 32'h99;
    tick();
    b_valid = 0;
    tick();
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b0, 5'd7, 32'h77}) begin failures++; $display("FAIL zero_b0 got=%0b/%0d/%0h exp=0/7/77", wr_en, wr_addr, wr_data); end
    b_valid = 1; b_addr = 13; b_data = 32'h13;
    tick();
    b_valid = 0;
    tick();
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd13, 32'h13}) begin failures++; $display("FAIL zero_b0_popped got=%0b/%0d/%0h exp=1/13/13", wr_en, wr_addr, wr_data); end
  endtask
  task automatic test_scoreboard;
    iss_valid = 1; iss_addr = 9;
    checks++; if (iss_ready !== 1'b1) begin failures++; $display("FAIL sb_iss_ready_pre got=%0b exp=1", iss_ready); end
    tick();
    iss_valid = 0; rs_addr = 9;
    checks++; if (stall !== SB) begin failures++; $display("FAIL sb_stall_rs got=%0b exp=%0b", stall, SB); end
    checks++; if (iss_ready !== !SB) begin failures++; $display("FAIL sb_iss_ready got=%0b exp=%0b", iss_ready, !SB); end
    rs_addr = 0; rt_addr = 9; #1;
    checks++; if (stall !== SB) begin failures++; $display("FAIL sb_stall_rt got=%0b exp=%0b", stall, SB); end
    rt_addr = 0; rd_addr = 9; rd_we = 0; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_stall_rd_nowe got=%0b exp=0", stall); end
    rd_we = 1; #1;
    checks++; if (stall !== SB) begin failures++; $display("FAIL sb_stall_rd got=%0b exp=%0b", stall, SB); end
    rd_we = 0; rd_addr = 0; rs_addr = 9;
    b_valid = 1; b_addr = 9; b_data = 32'h99;
    tick();
    b_valid = 0;
    checks++; if (stall !== SB) begin failures++; $display("FAIL sb_stall_queued got=%0b exp=%0b", stall, SB); end
    tick();
    checks++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd9, 32'h99}) begin failures++; $display("FAIL sb_commit got=%0b/%0d/%0h exp=1/9/99", wr_en, wr_addr, wr_data); end
    checks++; if ({stall, iss_ready} !== 2'b01) begin failures++; $display("FAIL sb_cleared got=%0b/%0b exp=0/1", stall, iss_ready); end
    rs_addr = 0;
  endtask
  task automatic test_reset_mid;
    iss_valid = 1; iss_addr = 12;
    a_valid = 1; a_addr = 1; a_data = 32'h1;
    b_valid = 1; b_addr = 20; b_data = 32'h20;
    tick();
    iss_valid = 0; b_addr = 21; b_data = 32'h21;
    tick();
    b_valid = 0; a_valid = 0;
    checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL mid_full got=%0b exp=0", b_ready); end
    reset = 1;
    tick();
    reset = 0; rs_addr = 12;
    checks++; if ({wr_en, wr_addr, b_ready, stall, iss_ready} !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b1}) begin failures++; $display("FAIL mid_reset got=%0b/%0d/%0b/%0b/%0b exp=0/0/1/0/1", wr_en, wr_addr, b_ready, stall, iss_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({wr_en, stall, iss_ready} !== 3'b001) begin failures++; $display("FAIL mid_after%0d got=%0b/%0b/%0b exp=0/0/1", i, wr_en, stall, iss_ready); end
    end
    rs_addr = 0;
  endtask
  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_zero_addr();
    test_scoreboard();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
